// File: rtl/frag_pkt_pkg.sv
// rtl/frag_pkt_pkg.sv - shared state encoding, flit width and flit-count helper for the packet fragmenter
package frag_pkt_pkg;

  // Flit payload width agreed with the lane link layer.
  localparam int FLIT_W_DEFAULT = 128;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } frag_state_e;

  function automatic int num_flits(input int pkt_w, input int flit_w);
    return (pkt_w + flit_w - 1) / flit_w;
  endfunction

endpackage

// File: rtl/fragment_pkt.sv
// rtl/fragment_pkt.sv - latches a wide packet and streams it out as LSB-first flits over valid/ready
// Optional FRAG_PARITY_EN: registered even parity of each presented flit on flit_parity.
module fragment_pkt
  import frag_pkt_pkg::*;
#(
  parameter int  PKT_WIDTH  = 1041,
  parameter int  FLIT_WIDTH = FLIT_W_DEFAULT,
  localparam int NUM_FLITS  = num_flits(PKT_WIDTH, FLIT_WIDTH),
  localparam int CNT_WIDTH  = $clog2(NUM_FLITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_pkt_send,
  input  logic [PKT_WIDTH-1:0]  pkt_data,
  output logic                  frag_busy,
  output logic                  done_frag,
  output logic                  pkt_drop,
  output logic                  flit_valid,
  input  logic                  flit_ready,
  output logic [FLIT_WIDTH-1:0] flit_data,
  output logic                  flit_first,
  output logic                  flit_last,
  output logic [CNT_WIDTH-1:0]  flit_idx,
  output logic                  flit_parity
);

  localparam int                   BUF_WIDTH = NUM_FLITS * FLIT_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_IDX  = CNT_WIDTH'(NUM_FLITS - 1);

  frag_state_e          state_q, state_d;
  logic [CNT_WIDTH-1:0] idx_q, idx_d;
  logic [BUF_WIDTH-1:0] buf_q, buf_d;
  logic                 done_q, done_d;
  logic                 drop_q, drop_d;
  logic [BUF_WIDTH-1:0] pkt_padded;

  assign pkt_padded = BUF_WIDTH'(pkt_data);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    done_d  = 1'b0;
    drop_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_pkt_send) begin
          buf_d   = pkt_padded;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (flit_ready && idx_q == LAST_IDX) begin
          // Last flit leaving: a strobe here is the next packet, not a drop.
          done_d = 1'b1;
          idx_d  = '0;
          if (valid_pkt_send) begin
            buf_d = pkt_padded;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (flit_ready) begin
            idx_d = idx_q + CNT_WIDTH'(1);
          end
          drop_d = valid_pkt_send;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      buf_q   <= '0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  assign flit_valid = (state_q == SEND);
  assign frag_busy  = flit_valid;
  assign flit_data  = flit_valid ? buf_q[int'(idx_q) * FLIT_WIDTH +: FLIT_WIDTH] : '0;
  assign flit_first = flit_valid && (idx_q == '0);
  assign flit_last  = flit_valid && (idx_q == LAST_IDX);
  assign flit_idx   = idx_q;
  assign done_frag  = done_q;
  assign pkt_drop   = drop_q;

`ifdef FRAG_PARITY_EN
  logic parity_q, parity_d;

  // Parity of the flit that will be presented next cycle, so it lines up with flit_data.
  always_comb begin
    parity_d = 1'b0;
    if (state_d == SEND) begin
      parity_d = ^buf_d[int'(idx_d) * FLIT_WIDTH +: FLIT_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign flit_parity = parity_q;
`else
  assign flit_parity = 1'b0;
`endif

endmodule

// File: tb/tb_fragment_pkt.sv
// tb/tb_fragment_pkt.sv - self-checking bench for fragment_pkt against a slicing reference model
module tb_fragment_pkt;
  import frag_pkt_pkg::*;

  localparam int PW = 1041;
  localparam int FW = 128;
  localparam int NF = num_flits(PW, FW);
  localparam int CW = $clog2(NF);

  typedef logic [PW-1:0] pkt_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_pkt_send = 1'b0;
  pkt_t          pkt_data = '0;
  logic          frag_busy, done_frag, pkt_drop, flit_valid;
  logic          flit_ready = 1'b0;
  logic [FW-1:0] flit_data;
  logic          flit_first, flit_last, flit_parity;
  logic [CW-1:0] flit_idx;

  int n_checks = 0;
  int n_fail   = 0;

  fragment_pkt dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_pkt_send (valid_pkt_send),
    .pkt_data       (pkt_data),
    .frag_busy      (frag_busy),
    .done_frag      (done_frag),
    .pkt_drop       (pkt_drop),
    .flit_valid     (flit_valid),
    .flit_ready     (flit_ready),
    .flit_data      (flit_data),
    .flit_first     (flit_first),
    .flit_last      (flit_last),
    .flit_idx       (flit_idx),
    .flit_parity    (flit_parity)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: pad the packet to a multiple of FW and shift the wanted flit down.
  function automatic logic [FW-1:0] model_flit(input pkt_t p, input int i);
    logic [NF*FW-1:0] wide;
    wide = '0;
    wide[PW-1:0] = p;
    return FW'(wide >> (i * FW));
  endfunction

  function automatic logic model_parity(input pkt_t p, input int i);
`ifdef FRAG_PARITY_EN
    logic [FW-1:0] f;
    int ones;
    f = model_flit(p, i);
    ones = 0;
    for (int b = 0; b < FW; b++) ones += int'(f[b]);
    return (ones % 2) == 1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic pkt_t rand_pkt();
    pkt_t r;
    logic [31:0] x;
    r = '0;
    for (int b = 0; b < PW; b += 32) begin
      x = $urandom;
      for (int j = 0; j < 32 && b + j < PW; j++) r[b+j] = x[j];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input pkt_t p);
    valid_pkt_send = 1'b1;
    pkt_data = p;
    tick();
    valid_pkt_send = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"},  flit_valid,  0);
    chk({tag, "_busy"},   frag_busy,   0);
    chk({tag, "_idx"},    flit_idx,    0);
    chk({tag, "_first"},  flit_first,  0);
    chk({tag, "_last"},   flit_last,   0);
    chk({tag, "_parity"}, flit_parity, 0);
  endtask

  // mode 0: ready held high; 1: 3-cycle stall at flit 2 then toggling; 2: random ready.
  task automatic collect(input pkt_t p, input int mode, input int drop_at, input bit b2b,
                         input pkt_t p2, input bit exp_done_first);
    int k;
    int stall;
    bit drop_pend;
    bit dropped;
    bit rdy;
    k = 0;
    stall = 0;
    drop_pend = 0;
    dropped = 0;
    for (int cyc = 0; cyc < 200 && k < NF; cyc++) begin
      valid_pkt_send = 1'b0;
      chk("valid", flit_valid, 1);
      chk("busy", frag_busy, 1);
      chk("done", done_frag, (cyc == 0) && exp_done_first);
      chk("drop", pkt_drop, drop_pend);
      drop_pend = 0;
      case (mode)
        0: rdy = 1'b1;
        1: begin
          if (k == 2 && stall < 3) begin
            rdy = 1'b0;
            stall++;
          end else if (stall >= 3) begin
            rdy = (cyc % 2) == 0;
          end else begin
            rdy = 1'b1;
          end
        end
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      flit_ready = rdy;
      chk("idx", flit_idx, k);
      chk("data", flit_data, model_flit(p, k));
      chk("first", flit_first, k == 0);
      chk("last", flit_last, k == NF - 1);
      chk("parity", flit_parity, model_parity(p, k));
      if (drop_at == k && !dropped) begin
        valid_pkt_send = 1'b1;
        pkt_data = rand_pkt();
        dropped = 1;
        drop_pend = 1;
      end
      if (b2b && rdy && k == NF - 1) begin
        valid_pkt_send = 1'b1;
        pkt_data = p2;
      end
      if (rdy) k++;
      tick();
    end
    valid_pkt_send = 1'b0;
    chk("all_flits", k, NF);
  endtask

  initial begin
    pkt_t kp, p1, p2;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset");
    chk("reset_done", done_frag, 0);
    chk("reset_drop", pkt_drop, 0);
    chk("reset_data", flit_data, 0);
    rst_n = 1'b1;
    tick();
    chk_idle("idle");

    // Known pattern, ready held high: flits on cycles 1..9, done on cycle 10.
    kp = '0;
    for (int w = 0; w < 32; w++) kp[w*32 +: 32] = {16'hC0DE, 16'(w)};
    kp[1040:1024] = 17'h12345;
    strobe(kp);
    collect(kp, 0, -1, 0, kp, 0);
    chk("single_done", done_frag, 1);
    chk_idle("single_end");
    tick();
    chk("single_done_pulse", done_frag, 0);
    chk("single_flit8", model_flit(kp, NF - 1), {111'b0, 17'h12345});

    // Parity corner: flit 0 all ones, flit 1 a single one.
    kp = rand_pkt();
    kp[FW-1:0] = '1;
    kp[2*FW-1:FW] = 128'h1;
    strobe(kp);
    collect(kp, 0, -1, 0, kp, 0);
    chk("par_done", done_frag, 1);
    tick();

    // Backpressure.
    p1 = rand_pkt();
    strobe(p1);
    collect(p1, 1, -1, 0, p1, 0);
    chk("bp_done", done_frag, 1);
    tick();

    // Back-to-back: second strobe rides the last-flit transfer.
    p1 = rand_pkt();
    p2 = rand_pkt();
    strobe(p1);
    collect(p1, 0, -1, 1, p2, 0);
    collect(p2, 2, -1, 0, p2, 1);
    chk("b2b_done", done_frag, 1);
    chk("b2b_drop", pkt_drop, 0);
    chk_idle("b2b_end");
    tick();
    chk("b2b_done_once", done_frag, 0);

    // Drop while busy at flit 4.
    p1 = rand_pkt();
    strobe(p1);
    collect(p1, 2, 4, 0, p1, 0);
    chk("drop_done", done_frag, 1);
    tick();
    chk("drop_no_done", done_frag, 0);
    chk("drop_pulse_gone", pkt_drop, 0);
    chk_idle("drop_end");

    // Asynchronous reset mid-packet at flit 5.
    p1 = rand_pkt();
    flit_ready = 1'b1;
    strobe(p1);
    repeat (5) tick();
    chk("rst_pre_idx", flit_idx, 5);
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    chk("async_rst_data", flit_data, 0);
    chk("async_rst_done", done_frag, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("post_rst_done", done_frag, 0);
    chk_idle("post_rst");
    p1 = rand_pkt();
    strobe(p1);
    collect(p1, 0, -1, 0, p1, 0);
    chk("post_rst_pkt_done", done_frag, 1);
    tick();

    // Random packets with random backpressure.
    for (int n = 0; n < 4; n++) begin
      p1 = rand_pkt();
      strobe(p1);
      collect(p1, 2, -1, 0, p1, 0);
      chk("rand_done", done_frag, 1);
      tick();
      chk_idle("rand_idle");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
